// File: rtl/seven_segment_capture_pkg.sv
// Shared definitions for the seven-segment encoder and capture blocks.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
// Both ends of a display link use this one table.
package seven_segment_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Nibble reported for a dark digit and for an unrecognised glyph.
  localparam logic [3:0] DIGIT_BLANK = 4'h0;
  localparam logic [3:0] DIGIT_ERR   = 4'hF;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       err;
  } seg_decode_t;

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational glyph decoder: exact match of a 7-bit active-low segment
// pattern against the shared table.
//   seg    : {g,f,e,d,c,b,a}, active-low
//   result : {digit, blank, err}; blank -> DIGIT_BLANK, unknown -> DIGIT_ERR
module seven_segment_decode
  import seven_segment_capture_pkg::*;
(
  input  logic [6:0]  seg,
  output seg_decode_t result
);

  always_comb begin
    result = '{digit: DIGIT_ERR, blank: 1'b0, err: 1'b1};
    case (seg)
      SEG_0:     result = '{digit: 4'd0, blank: 1'b0, err: 1'b0};
      SEG_1:     result = '{digit: 4'd1, blank: 1'b0, err: 1'b0};
      SEG_2:     result = '{digit: 4'd2, blank: 1'b0, err: 1'b0};
      SEG_3:     result = '{digit: 4'd3, blank: 1'b0, err: 1'b0};
      SEG_4:     result = '{digit: 4'd4, blank: 1'b0, err: 1'b0};
      SEG_5:     result = '{digit: 4'd5, blank: 1'b0, err: 1'b0};
      SEG_6:     result = '{digit: 4'd6, blank: 1'b0, err: 1'b0};
      SEG_7:     result = '{digit: 4'd7, blank: 1'b0, err: 1'b0};
      SEG_8:     result = '{digit: 4'd8, blank: 1'b0, err: 1'b0};
      SEG_9:     result = '{digit: 4'd9, blank: 1'b0, err: 1'b0};
      SEG_BLANK: result = '{digit: DIGIT_BLANK, blank: 1'b1, err: 1'b0};
      default:   result = '{digit: DIGIT_ERR, blank: 1'b0, err: 1'b1};
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed seven-segment display bus. Samples the
// active-low segment and anode lines, waits for each digit's glyph to be
// stable, decodes it and assembles a frame of NUM_DIGITS digits that is
// offered on a valid/ready interface.
//   clk, rst_n   : clock, synchronous active-low reset
//   seg_in       : segment lines {g,f,e,d,c,b,a}, active-low
//   an_in        : digit enables, active-low, one low bit selects a digit
//   frame_digits : digit i in bits [4i+3:4i]
//   frame_blank  : digit i was dark;  frame_err : digit i was unrecognised
//   frame_valid  : frame held until frame_ready is seen
//   overrun      : one-cycle pulse when a completed frame had to be dropped
// STABLE_CYCLES must be 2..65535, SYNC_STAGES at least 2.
module seven_segment_capture
  import seven_segment_capture_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  // Counter value seen while the STABLE_CYCLES-th identical sample arrives.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);

  logic [6:0]            seg_sync_reg [SYNC_STAGES];
  logic [NUM_DIGITS-1:0] an_sync_reg  [SYNC_STAGES];
  logic [6:0]            seg_s, seg_prev_reg;
  logic [NUM_DIGITS-1:0] an_s, an_prev_reg;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic                  sel_valid, same, capture;
  seg_decode_t           dec;

  logic [3:0]              stage_digit_reg [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] stage_digits;
  logic [NUM_DIGITS-1:0]   stage_blank_reg, stage_err_reg;
  logic [NUM_DIGITS-1:0]   mask_reg, mask_next;
  logic [4*NUM_DIGITS-1:0] frame_digits_reg;
  logic [NUM_DIGITS-1:0]   frame_blank_reg, frame_err_reg;
  logic                    frame_valid_reg, overrun_reg;
  logic                    complete, load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync_reg[i] <= '0;
        an_sync_reg[i]  <= '0;
      end
    end else begin
      seg_sync_reg[0] <= seg_in;
      an_sync_reg[0]  <= an_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seg_sync_reg[i] <= seg_sync_reg[i-1];
        an_sync_reg[i]  <= an_sync_reg[i-1];
      end
    end
  end

  assign seg_s = seg_sync_reg[SYNC_STAGES-1];
  assign an_s  = an_sync_reg[SYNC_STAGES-1];

  // Exactly one anode low: the inverted vector is a non-zero power of two.
  assign sel_onehot = ~an_s;
  assign sel_valid  = (sel_onehot != '0) &&
                      ((sel_onehot & (sel_onehot - NUM_DIGITS'(1))) == '0);
  assign same       = (seg_s == seg_prev_reg) && (an_s == an_prev_reg);
  // Fires only on the transition to CNT_MAX; saturation blocks re-capture.
  assign capture    = same && sel_valid && (cnt_reg == CNT_FIRE);

  always_comb begin
    cnt_next = '0;
    if (same && sel_valid) begin
      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_prev_reg <= '0;
      an_prev_reg  <= '0;
      cnt_reg      <= '0;
    end else begin
      seg_prev_reg <= seg_s;
      an_prev_reg  <= an_s;
      cnt_reg      <= cnt_next;
    end
  end

  seven_segment_decode u_decode (
    .seg    (seg_s),
    .result (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) stage_digit_reg[i] <= '0;
      stage_blank_reg <= '0;
      stage_err_reg   <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_onehot[i]) begin
          stage_digit_reg[i] <= dec.digit;
          stage_blank_reg[i] <= dec.blank;
          stage_err_reg[i]   <= dec.err;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pack
    assign stage_digits[4*gi +: 4] = stage_digit_reg[gi];
  end

  assign complete = &mask_reg;
  assign load     = complete && (!frame_valid_reg || frame_ready);

  // A completing frame clears the mask; a capture in the same cycle still
  // starts the next frame.
  always_comb begin
    mask_next = complete ? '0 : mask_reg;
    if (capture) mask_next = mask_next | sel_onehot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_reg         <= '0;
      frame_digits_reg <= '0;
      frame_blank_reg  <= '0;
      frame_err_reg    <= '0;
      frame_valid_reg  <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      mask_reg    <= mask_next;
      overrun_reg <= complete && frame_valid_reg && !frame_ready;
      if (load) begin
        frame_digits_reg <= stage_digits;
        frame_blank_reg  <= stage_blank_reg;
        frame_err_reg    <= stage_err_reg;
        frame_valid_reg  <= 1'b1;
      end else if (frame_valid_reg && frame_ready) begin
        frame_valid_reg  <= 1'b0;
      end
    end
  end

  assign frame_digits = frame_digits_reg;
  assign frame_blank  = frame_blank_reg;
  assign frame_err    = frame_err_reg;
  assign frame_valid  = frame_valid_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture (4 digits, 4 stable samples,
// 2 sync stages) with a cycle-level reference model and literal checks.
module tb_seven_segment_capture;

  localparam int NUM    = 4;
  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] frame_digits;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  seven_segment_capture #(
    .NUM_DIGITS    (NUM),
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .frame_digits (frame_digits),
    .frame_blank  (frame_blank),
    .frame_err    (frame_err),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  // ---------------- reference model ----------------
  logic [10:0] pin_q[$];
  logic [10:0] prev_s;
  int          run;
  logic [3:0]  st_dig [4];
  logic [3:0]  st_blank, st_err, got;
  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_err;
  logic        m_valid, m_ovr;
  bit          m_started = 0;

  always @(posedge clk) begin
    logic [10:0] s;
    int zc;
    int idx;
    logic [3:0] d;
    logic b;
    logic e;
    if (!rst_n) begin
      pin_q = {};
      for (int i = 0; i < SYNC; i++) pin_q.push_back(11'd0);
      prev_s = '0; run = 0; got = '0; st_blank = '0; st_err = '0;
      for (int i = 0; i < NUM; i++) st_dig[i] = '0;
      m_digits = '0; m_blank = '0; m_err = '0; m_valid = 0; m_ovr = 0;
      m_started = 1;
    end else if (m_started) begin
      // Logic sees the pins as they were SYNC edges ago.
      s = pin_q.pop_front();
      pin_q.push_back({seg_in, an_in});
      m_ovr = 0;
      if (got == 4'hF) begin
        if (!m_valid || frame_ready) begin
          m_digits = {st_dig[3], st_dig[2], st_dig[1], st_dig[0]};
          m_blank  = st_blank;
          m_err    = st_err;
          m_valid  = 1;
        end else begin
          m_ovr = 1;
        end
        got = '0;
      end else if (m_valid && frame_ready) begin
        m_valid = 0;
      end
      zc = 0; idx = 0;
      for (int i = 0; i < NUM; i++) if (!s[i]) begin zc++; idx = i; end
      if (zc == 1 && s == prev_s) run++;
      else run = (zc == 1) ? 1 : 0;
      if (zc == 1 && run == STABLE) begin
        d = 4'hF; b = 0; e = 1;
        if (s[10:4] == 7'b1111111) begin d = 4'h0; b = 1; e = 0; end
        else for (int k = 0; k < 10; k++) if (s[10:4] == glyph(k)) begin d = 4'(k); e = 0; end
        st_dig[idx] = d; st_blank[idx] = b; st_err[idx] = e; got[idx] = 1;
      end
      prev_s = s;
    end
  end

  // ---------------- per-cycle compare ----------------
  int ovr_seen = 0;
  int loads    = 0;
  bit prev_v   = 0;

  always @(negedge clk) begin
    if (m_started) begin
      check("cyc_digits",  32'(frame_digits), 32'(m_digits));
      check("cyc_blank",   32'(frame_blank),  32'(m_blank));
      check("cyc_err",     32'(frame_err),    32'(m_err));
      check("cyc_valid",   32'(frame_valid),  32'(m_valid));
      check("cyc_overrun", 32'(overrun),      32'(m_ovr));
      if (overrun === 1'b1) ovr_seen++;
      if (frame_valid === 1'b1 && !prev_v) begin
        loads++;
        $display("frame digits=%h blank=%b err=%b", frame_digits, frame_blank, frame_err);
      end
      prev_v = (frame_valid === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic show(input logic [6:0] s, input logic [3:0] a, input int n);
    seg_in = s;
    an_in  = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic send4(input int d0, input int d1, input int d2, input int d3);
    show(glyph(d0), an_of(0), 8);
    show(glyph(d1), an_of(1), 8);
    show(glyph(d2), an_of(2), 8);
    show(glyph(d3), an_of(3), 8);
  endtask

  initial begin
    int ovr0;
    int loads0;
    rst_n = 1'b0;
    frame_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seg_in = 7'($urandom);
      an_in  = 4'($urandom);
      @(negedge clk);
    end
    check("rst_digits",  32'(frame_digits), 32'h0);
    check("rst_blank",   32'(frame_blank),  32'h0);
    check("rst_err",     32'(frame_err),    32'h0);
    check("rst_valid",   32'(frame_valid),  32'h0);
    check("rst_overrun", 32'(overrun),      32'h0);
    rst_n = 1'b1;

    // Basic frame and latency: valid rises 2 cycles after the 4th capture.
    show(glyph(1), an_of(0), 8);
    show(glyph(2), an_of(1), 8);
    show(glyph(3), an_of(2), 8);
    show(glyph(4), an_of(3), 6);
    check("lat_valid_low", 32'(frame_valid), 32'h0);
    @(negedge clk);
    check("lat_valid_high", 32'(frame_valid),  32'h1);
    check("a_digits",       32'(frame_digits), 32'h4321);
    check("a_blank",        32'(frame_blank),  32'h0);
    check("a_err",          32'(frame_err),    32'h0);
    check("model_a_digits", 32'(m_digits),     32'h4321);
    @(negedge clk);

    // Glitch rejection on digit 0.
    show(glyph(2), an_of(0), 2);
    send4(3, 2, 3, 4);
    check("glitch_digits", 32'(frame_digits), 32'h4323);

    // Blank and unrecognised glyphs.
    show(glyph(1), an_of(0), 8);
    show(glyph(2), an_of(1), 8);
    show(7'b1111111, an_of(2), 8);
    show(7'b0101010, an_of(3), 8);
    check("be_digits", 32'(frame_digits), 32'hF021);
    check("be_blank",  32'(frame_blank),  32'h4);
    check("be_err",    32'(frame_err),    32'h8);
    check("model_be_blank", 32'(m_blank), 32'h4);

    // Backpressure: second frame dropped with an overrun pulse.
    frame_ready = 1'b0;
    send4(1, 2, 3, 4);
    check("bp_first_valid", 32'(frame_valid), 32'h1);
    ovr0 = ovr_seen;
    send4(5, 6, 7, 8);
    check("bp_overrun_pulses", 32'(ovr_seen - ovr0), 32'h1);
    check("bp_digits_held",    32'(frame_digits),    32'h4321);
    check("bp_valid_held",     32'(frame_valid),     32'h1);
    frame_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_fall", 32'(frame_valid), 32'h0);

    // Acceptance in the same cycle as completion.
    frame_ready = 1'b0;
    send4(9, 0, 1, 2);
    check("sim_first_digits", 32'(frame_digits), 32'h2109);
    ovr0 = ovr_seen;
    show(glyph(3), an_of(0), 8);
    show(glyph(4), an_of(1), 8);
    show(glyph(5), an_of(2), 8);
    show(glyph(6), an_of(3), 6);
    frame_ready = 1'b1;
    @(negedge clk);
    check("sim_valid",   32'(frame_valid),  32'h1);
    check("sim_digits",  32'(frame_digits), 32'h6543);
    check("sim_overrun", 32'(overrun),      32'h0);
    frame_ready = 1'b0;
    @(negedge clk);
    check("sim_valid_stays", 32'(frame_valid),       32'h1);
    check("sim_no_overrun",  32'(ovr_seen - ovr0),   32'h0);
    frame_ready = 1'b1;
    @(negedge clk);
    check("sim_drained", 32'(frame_valid), 32'h0);

    // Invalid selects must not capture anything.
    show(glyph(7), an_of(0), 8);
    show(glyph(7), an_of(1), 8);
    show(glyph(9), 4'b1111, 20);
    show(glyph(9), 4'b1100, 20);
    loads0 = loads;
    show(glyph(2), an_of(2), 8);
    check("inv_no_early_frame", 32'(loads - loads0), 32'h0);
    show(glyph(3), an_of(3), 8);
    check("inv_one_frame", 32'(loads - loads0), 32'h1);
    check("inv_digits",    32'(frame_digits),   32'h3277);

    // Reset mid-frame discards partial captures.
    show(glyph(8), an_of(0), 8);
    show(glyph(8), an_of(1), 8);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_digits", 32'(frame_digits), 32'h0);
    check("mrst_valid",  32'(frame_valid),  32'h0);
    rst_n = 1'b1;
    loads0 = loads;
    show(glyph(2), an_of(2), 8);
    show(glyph(3), an_of(3), 8);
    check("mrst_no_stale_frame", 32'(loads - loads0), 32'h0);
    show(glyph(5), an_of(0), 8);
    show(glyph(6), an_of(1), 8);
    check("mrst_one_frame", 32'(loads - loads0), 32'h1);
    check("mrst_digits_new", 32'(frame_digits), 32'h3265);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
